// File: rtl/sram_wr_sched_if.sv
// Bundle of the scheduler's control, upstream stream and SRAM write-port signals.
// master: the scheduler itself; slave: the surrounding environment.
interface sram_wr_sched_if #(
    parameter int unsigned NUM_BANK   = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned PORT_WIDTH = 128
);
    logic                  start;
    logic [NUM_BANK-1:0]   Wr_Req;
    logic [ADDR_WIDTH:0]   Wr_Len;
    logic                  IFSRAM_Conf_rdy;
    logic                  in_valid;
    logic [PORT_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [5:0]            SRAMIF_Wr_ID;
    logic [1:0]            State_Wr;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [PORT_WIDTH-1:0] data_in;
    logic                  write_SRAM_done;

    modport master (
        input  start, Wr_Req, Wr_Len, IFSRAM_Conf_rdy, in_valid, in_data,
        output in_ready, SRAMIF_Wr_ID, State_Wr, write_en, addr_w, data_in, write_SRAM_done
    );

    modport slave (
        output start, Wr_Req, Wr_Len, IFSRAM_Conf_rdy, in_valid, in_data,
        input  in_ready, SRAMIF_Wr_ID, State_Wr, write_en, addr_w, data_in, write_SRAM_done
    );
endinterface

// File: rtl/sram_wr_sched.sv
// SRAM write scheduler: picks an empty bank, waits for the channel, streams one block fill.
// Define WR_SCHED_RR_EN for round-robin bank selection; otherwise lowest index wins.
module sram_wr_sched #(
    parameter int unsigned NUM_BANK   = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned PORT_WIDTH = 128,
    parameter int unsigned SRAM_DEPTH = 512
) (
    input logic             clk,
    input logic             rst,
    sram_wr_sched_if.master bus
);
    localparam logic [1:0] WR_IDLE      = 2'b00;
    localparam logic [1:0] WR_REQ_READY = 2'b01;
    localparam logic [1:0] WR_WRITE     = 2'b11;
    localparam logic [1:0] WR_DONE      = 2'b10;

    localparam logic [ADDR_WIDTH:0] LEN_DEPTH = (ADDR_WIDTH + 1)'(SRAM_DEPTH);

    logic [1:0]            state_q, state_d;
    logic [3:0]            wr_id_q, wr_id_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   len_eff;
    logic [NUM_BANK-1:0]   req_vec;
    logic                  sel_valid;
    logic [3:0]            sel_off;
    logic [3:0]            sel_idx;
    logic                  in_ready_w;
    logic                  beat;
    logic                  last_beat;

`ifdef WR_SCHED_RR_EN
    logic [3:0] ptr_q, ptr_d;

    // Rotate so that bit 0 is the bank the search starts from.
    assign req_vec = NUM_BANK'({bus.Wr_Req, bus.Wr_Req} >> ptr_q);
    assign sel_idx = 4'((32'(ptr_q) + 32'(sel_off)) % NUM_BANK);
`else
    assign req_vec = bus.Wr_Req;
    assign sel_idx = sel_off;
`endif

    always_comb begin
        sel_valid = 1'b0;
        sel_off   = '0;
        for (int k = NUM_BANK - 1; k >= 0; k--) begin
            if (req_vec[k]) begin
                sel_valid = 1'b1;
                sel_off   = 4'(k);
            end
        end
    end

    assign len_eff = (bus.Wr_Len == '0 || bus.Wr_Len > LEN_DEPTH) ? LEN_DEPTH : bus.Wr_Len;

    assign in_ready_w = (state_q == WR_WRITE);
    assign beat       = bus.in_valid & in_ready_w;
    assign last_beat  = ({1'b0, cnt_q} == len_q - 1'b1);

    always_comb begin
        state_d = state_q;
        wr_id_d = wr_id_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
`ifdef WR_SCHED_RR_EN
        ptr_d   = ptr_q;
`endif
        if (bus.start) begin
            // Layer restart abandons any fill in flight without a completion pulse.
            state_d = WR_IDLE;
            wr_id_d = '0;
            cnt_d   = '0;
            len_d   = '0;
`ifdef WR_SCHED_RR_EN
            ptr_d   = '0;
`endif
        end else begin
            unique case (state_q)
                WR_IDLE: begin
                    if (sel_valid) begin
                        wr_id_d = sel_idx;
                        len_d   = len_eff;
                        cnt_d   = '0;
                        state_d = WR_REQ_READY;
`ifdef WR_SCHED_RR_EN
                        ptr_d   = 4'((32'(sel_idx) + 32'd1) % NUM_BANK);
`endif
                    end
                end
                WR_REQ_READY: begin
                    if (bus.IFSRAM_Conf_rdy) begin
                        cnt_d   = '0;
                        state_d = WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    if (beat) begin
                        cnt_d = cnt_q + 1'b1;
                        if (last_beat) begin
                            state_d = WR_DONE;
                        end
                    end
                end
                WR_DONE: state_d = WR_IDLE;
                default: state_d = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_IDLE;
            wr_id_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef WR_SCHED_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_id_q <= wr_id_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef WR_SCHED_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.in_ready        = in_ready_w;
    assign bus.write_en        = beat;
    assign bus.addr_w          = cnt_q;
    assign bus.data_in         = PORT_WIDTH'(bus.in_data);
    assign bus.State_Wr        = state_q;
    assign bus.SRAMIF_Wr_ID    = {2'b00, wr_id_q};
    assign bus.write_SRAM_done = (state_q == WR_DONE);
endmodule

// File: tb/tb_sram_wr_sched.sv
// Randomized scoreboard bench for sram_wr_sched; expected beats and completions are queued
// by the driver from a bank/length reference model and consumed by a negedge monitor.
module tb_sram_wr_sched;
    localparam int NB    = 16;
    localparam int AW    = 9;
    localparam int PW    = 128;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_wr_sched_if #(.NUM_BANK(NB), .ADDR_WIDTH(AW), .PORT_WIDTH(PW)) bus ();

    sram_wr_sched #(
        .NUM_BANK(NB), .ADDR_WIDTH(AW), .PORT_WIDTH(PW), .SRAM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          bank;
        int          addr;
        logic [PW-1:0] data;
    } beat_t;

    beat_t      beat_q[$];
    int         done_q[$];
    int         checks = 0;
    int         errors = 0;
    int         model_ptr = 0;
    logic       rec = 1'b0;
    logic [1:0] hist[$];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requesting bank scanning upward from the start point.
    function automatic int pick(input logic [NB-1:0] req);
        int start;
`ifdef WR_SCHED_RR_EN
        start = model_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NB; k++) begin
            if (req[(start + k) % NB]) return (start + k) % NB;
        end
        return -1;
    endfunction

    function automatic int eff_len(input int l);
        return (l == 0 || l > DEPTH) ? DEPTH : l;
    endfunction

    always @(negedge clk) begin
        beat_t b;
        int    id;
        if (!rst) begin
            if (rec) hist.push_back(bus.State_Wr);
            if (bus.write_en === 1'b1) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d required=no write", bus.addr_w);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_addr", PW'(bus.addr_w), PW'(b.addr));
                    check("beat_data", bus.data_in, b.data);
                    check("beat_id", PW'(bus.SRAMIF_Wr_ID), PW'(b.bank));
                end
            end
            if (bus.write_SRAM_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    id = done_q.pop_front();
                    check("done_id", PW'(bus.SRAMIF_Wr_ID), PW'(id));
                    check("done_all_beats_written", PW'(beat_q.size()), '0);
                end
            end
        end
    end

    task automatic do_fill(input logic [NB-1:0] req, input int len_in, input int conf_delay,
                           input bit gaps, input int abort_after, input bit abort_rst);
        int            bank;
        int            elen;
        int            sent;
        int            guard;
        logic          v;
        logic [PW-1:0] d;
        check("idle_before_fill", PW'(bus.State_Wr), PW'(2'b00));
        bank = pick(req);
        elen = eff_len(len_in);
`ifdef WR_SCHED_RR_EN
        model_ptr = (bank + 1) % NB;
`endif
        bus.Wr_Req = req;
        bus.Wr_Len = (AW + 1)'(len_in);
        @(posedge clk); #1;
        check("state_req_ready", PW'(bus.State_Wr), PW'(2'b01));
        check("select_id", PW'(bus.SRAMIF_Wr_ID), PW'(bank));
        // Requests changing after the select edge must not disturb the latched target.
        bus.Wr_Req = NB'($urandom);
        for (int i = 0; i < conf_delay; i++) begin
            check("conf_stall_state", PW'(bus.State_Wr), PW'(2'b01));
            check("conf_stall_ready", PW'(bus.in_ready), '0);
            @(posedge clk); #1;
        end
        bus.IFSRAM_Conf_rdy = 1'b1;
        bus.Wr_Req          = '0;
        @(posedge clk); #1;
        bus.IFSRAM_Conf_rdy = 1'b0;
        check("state_write", PW'(bus.State_Wr), PW'(2'b11));
        check("held_id", PW'(bus.SRAMIF_Wr_ID), PW'(bank));
        sent  = 0;
        guard = 0;
        while (sent < elen && guard < 20000) begin
            if (abort_after >= 0 && sent == abort_after) break;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = {$urandom, $urandom, $urandom, $urandom};
            bus.in_valid = v;
            bus.in_data  = d;
            if (v) beat_q.push_back('{bank, sent, d});
            @(posedge clk); #1;
            if (v) sent++;
            guard++;
        end
        if (abort_after >= 0) begin
            bus.in_valid = 1'b0;
            if (abort_rst) rst = 1'b1;
            else bus.start = 1'b1;
            model_ptr = 0;
            @(posedge clk); #1;
            rst       = 1'b0;
            bus.start = 1'b0;
            check("abort_state", PW'(bus.State_Wr), PW'(2'b00));
            check("abort_addr", PW'(bus.addr_w), '0);
            check("abort_id", PW'(bus.SRAMIF_Wr_ID), '0);
            check("abort_ready", PW'(bus.in_ready), '0);
            check("abort_no_done", PW'(bus.write_SRAM_done), '0);
            @(posedge clk); #1;
        end else begin
            done_q.push_back(bank);
            check("state_done", PW'(bus.State_Wr), PW'(2'b10));
            // Offer one extra word during WR_DONE; it must not be written.
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("state_idle_after_done", PW'(bus.State_Wr), PW'(2'b00));
            check("done_cleared", PW'(bus.write_SRAM_done), '0);
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    exp_seq [8];
        logic [NB-1:0] r;
        int            l;
        int            ab;
        exp_seq = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
        rst                 = 1'b1;
        bus.start           = 1'b0;
        bus.Wr_Req          = '0;
        bus.Wr_Len          = '0;
        bus.IFSRAM_Conf_rdy = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_data         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", PW'(bus.State_Wr), '0);
        check("rst_id", PW'(bus.SRAMIF_Wr_ID), '0);
        check("rst_addr", PW'(bus.addr_w), '0);
        check("rst_ready", PW'(bus.in_ready), '0);
        check("rst_write_en", PW'(bus.write_en), '0);
        check("rst_done", PW'(bus.write_SRAM_done), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        rec = 1'b1;
        do_fill(16'h0004, 4, 0, 1'b0, -1, 1'b0);
        rec = 1'b0;
        check("seq_len", PW'(hist.size() >= 8), PW'(1));
        for (int i = 0; i < 8 && i < hist.size(); i++) check("state_seq", PW'(hist[i]), PW'(exp_seq[i]));

        do_fill(16'h0100, 3, 1, 1'b1, -1, 1'b0);
        do_fill(16'h0020, 0, 0, 1'b1, -1, 1'b0);
        do_fill(16'h8000, 600, 2, 1'b0, -1, 1'b0);
        do_fill(16'h0040, 1, 0, 1'b1, -1, 1'b0);
        do_fill(16'h0009, 2, 0, 1'b0, -1, 1'b0);
        do_fill(16'h0009, 2, 0, 1'b0, -1, 1'b0);
        do_fill(16'h0002, 5, 50, 1'b1, -1, 1'b0);
        do_fill(16'h0010, 8, 0, 1'b0, 2, 1'b0);
        do_fill(16'h0010, 8, 0, 1'b0, 2, 1'b1);

        for (int n = 0; n < 20; n++) begin
            r = NB'($urandom);
            if (r == '0) r = NB'(1);
            case ($urandom_range(0, 7))
                0:       l = 0;
                1:       l = 600;
                2:       l = 1;
                3:       l = 512;
                default: l = $urandom_range(1, 24);
            endcase
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, eff_len(l) - 1) : -1;
            do_fill(r, l, $urandom_range(0, 4), 1'b1, ab, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        check("beats_drained", PW'(beat_q.size()), '0);
        check("dones_drained", PW'(done_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_wr_sched.md
SRAM_WR_SCHED -- requirements
Module: sram_wr_sched

Interface
REQ-001 The parameter list SHALL be exactly: NUM_BANK, default 16, number of SRAM blocks served (1..16); ADDR_WIDTH, default 9, word address width; PORT_WIDTH, default 128, data width; SRAM_DEPTH, default 512, words per block.
REQ-002 The port list SHALL be, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  layer restart; synchronous soft clear.
- Wr_Req  in  NUM_BANK  bit i high means block i is EMPTY and writable.
- Wr_Len  in  ADDR_WIDTH+1  number of words per block fill.
- IFSRAM_Conf_rdy  in  1  interface confirms the write channel.
- in_valid  in  1  upstream data valid.
- in_data  in  PORT_WIDTH  upstream data word.
- in_ready  out  1  scheduler accepts in_data.
- SRAMIF_Wr_ID  out  6  target block; [3:0] is the index, [5:4] is always 0.
- State_Wr  out  2  write-side state code.
- write_en  out  1  SRAM write strobe.
- addr_w  out  ADDR_WIDTH  SRAM write address.
- data_in  out  PORT_WIDTH  SRAM write data.
- write_SRAM_done  out  1  one-cycle fill-complete pulse.

Function
REQ-003 The FSM SHALL have four states, and State_Wr SHALL equal the state code: WR_IDLE=00, WR_REQ_READY=01, WR_WRITE=11, WR_DONE=10.
REQ-004 In WR_IDLE, when start=0 and |Wr_Req=1, the block SHALL select one requesting bank, latch its index into SRAMIF_Wr_ID[3:0], latch the effective length, and go to WR_REQ_READY on the next edge.
REQ-005 Effective length SHALL be Wr_Len when 1 <= Wr_Len <= SRAM_DEPTH; Wr_Len=0 or Wr_Len>SRAM_DEPTH SHALL be treated as SRAM_DEPTH.
REQ-006 In WR_REQ_READY, State_Wr and SRAMIF_Wr_ID SHALL hold; on IFSRAM_Conf_rdy=1 the FSM SHALL go to WR_WRITE with the address counter at 0, otherwise it SHALL stay in WR_REQ_READY indefinitely.
REQ-007 in_ready SHALL be 1 only in WR_WRITE.
REQ-008 write_en SHALL equal in_valid & in_ready, combinationally.
REQ-009 addr_w SHALL equal the address counter, and data_in SHALL equal in_data.
REQ-010 The address counter SHALL increment by 1 on each accepted beat.
REQ-011 Gaps in in_valid SHALL stall the counter without error.
REQ-012 When the beat with counter = length-1 is accepted, the FSM SHALL go to WR_DONE.
REQ-013 No further beats SHALL be accepted in the same block fill.
REQ-014 In WR_DONE, write_SRAM_done SHALL be 1 for exactly one cycle, and the next state SHALL be WR_IDLE unconditionally.
REQ-015 write_SRAM_done SHALL be 0 in every other state.
REQ-016 Minimum spacing between two fills SHALL be: WR_DONE, then WR_IDLE, then WR_REQ_READY. A bank whose Wr_Req is 1 in WR_IDLE SHALL be selectable immediately, even if it was served last.
REQ-017 Wr_Req changes after the select edge SHALL NOT affect the latched target.
REQ-018 start=1 SHALL have priority over all transitions, in any state. On the next edge it SHALL force WR_IDLE and clear the counter, and no write_SRAM_done SHALL be issued. A partial fill SHALL be abandoned.
REQ-019 SRAMIF_Wr_ID, addr_w and the arbitration pointer SHALL be cleared to 0 on that same edge.
REQ-020 SRAMIF_Wr_ID SHALL be stable from the select edge until WR_IDLE is re-entered.

Reset
REQ-021 With rst=1 at a clock edge, the state SHALL become WR_IDLE.
REQ-022 On that edge, State_Wr, SRAMIF_Wr_ID, addr_w, the counter, the latched length and the arbitration pointer SHALL be 0.
REQ-023 With rst=1, in_ready, write_en and write_SRAM_done SHALL be 0 from the first cycle after the reset edge.
REQ-024 Reset SHALL take effect mid-fill without any completion pulse.

Configuration
REQ-025 Macro WR_SCHED_RR_EN SHALL select the arbitration mode.
REQ-026 When WR_SCHED_RR_EN is defined, selection SHALL be round-robin: the search starts at (last served index + 1) mod NUM_BANK, and the pointer updates on each select.
REQ-027 When WR_SCHED_RR_EN is undefined, selection SHALL be fixed priority, lowest requesting index first, and no pointer register SHALL exist.

Verification
REQ-028 Basic fill: Wr_Req=0x0004, Wr_Len=4, Conf_rdy=1 one cycle after WR_REQ_READY, in_valid held at 1 -> SRAMIF_Wr_ID=2; write_en on 4 cycles with addr_w 0,1,2,3; write_SRAM_done pulses once in the cycle after addr 3; State_Wr sequence 00,01,11,11,11,11,10,00.
REQ-029 Backpressure: Wr_Len=3 with in_valid pattern 1,0,0,1,0,1 -> exactly 3 write_en pulses at addr 0,1,2; counter holds during gaps.
REQ-030 Length edge cases: Wr_Len=0 and Wr_Len=600 -> 512 beats each, last addr_w=511; Wr_Len=1 -> a single beat at addr 0, then WR_DONE.
REQ-031 Arbitration: Wr_Req=0x0009 held over two fills -> RR build serves 0 then 3; non-RR build serves 0 then 0.
REQ-032 Abort: start=1 after 2 of 8 beats -> State_Wr=00 on the next cycle, no write_SRAM_done, addr_w=0. The same check SHALL be repeated with rst=1.
REQ-033 Conf stall: Conf_rdy held 0 for 50 cycles -> State_Wr stays 01, in_ready=0, no write_en.
